efuse_macro_emu: RTL

//  Synthesizable emulation of the 256-bit eFuse macro: the responder end of the macro pin interface
//  (pgmen/rden/aen/addr -> rdata) driven by efuse_ctrl. Used in FPGA prototypes and closed-loop sims
//  in place of the hard macro. It checks strobe timing, stores bits with fuse semantics (0->1 only,

---
 rtl/efuse_macro_emu.sv | 123 ++++++++++++
 1 files changed

// File: rtl/efuse_macro_emu.sv
// Synthesizable stand-in for the 256-bit eFuse hard macro. Tracks each
// AEN strobe, checks its width and mode stability, and then either returns
// one byte or blows one bit. A blown bit stays at 1 until reset.
module efuse_macro_emu #(
  parameter int unsigned    TRD_MIN   = 3,
  parameter int unsigned    TPGM_MIN  = 3,
  parameter logic [255:0]   INIT_FUSE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         efuse_pgmen_i,
  input  logic         efuse_rden_i,
  input  logic         efuse_aen_i,
  input  logic [7:0]   efuse_addr_i,
  input  logic         err_clr_i,
  output logic [7:0]   efuse_rdata_o,
  output logic [255:0] fuse_bits_o,
  output logic         err_rd_short_o,
  output logic         err_pgm_short_o,
  output logic         err_mode_o,
  output logic         emu_busy_o
);

  typedef enum logic [1:0] {IDLE, RD_ACT, PGM_ACT, IGNORE} state_t;

  state_t       state, state_nxt;
  logic         aen_q;
  logic [9:0]   cnt, cnt_nxt;
  logic [7:0]   addr_lat, addr_nxt;
  logic [7:0]   rdata_nxt;
  logic [255:0] fuse;
  logic         pgm_wr;
  logic         set_rd_short, set_pgm_short, set_mode;
  logic         mode_bad;

  assign fuse_bits_o = fuse;
  assign emu_busy_o  = (state != IDLE);

  // State, strobe tracking, fuse array, read data and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      aen_q           <= 1'b0;
      cnt             <= '0;
      addr_lat        <= '0;
      efuse_rdata_o   <= '0;
      fuse            <= INIT_FUSE;
      err_rd_short_o  <= 1'b0;
      err_pgm_short_o <= 1'b0;
      err_mode_o      <= 1'b0;
    end else begin
      state         <= state_nxt;
      aen_q         <= efuse_aen_i;
      cnt           <= cnt_nxt;
      addr_lat      <= addr_nxt;
      efuse_rdata_o <= rdata_nxt;
      if (pgm_wr) fuse[addr_lat] <= 1'b1;
      // a newly detected error in the clear cycle survives the clear
      err_rd_short_o  <= (err_rd_short_o  & ~err_clr_i) | set_rd_short;
      err_pgm_short_o <= (err_pgm_short_o & ~err_clr_i) | set_pgm_short;
      err_mode_o      <= (err_mode_o      & ~err_clr_i) | set_mode;
    end
  end

  // Next-state, strobe-width counting and end-of-strobe actions
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    addr_nxt      = addr_lat;
    rdata_nxt     = efuse_rdata_o;
    pgm_wr        = 1'b0;
    set_rd_short  = 1'b0;
    set_pgm_short = 1'b0;
    set_mode      = 1'b0;
    mode_bad      = 1'b0;
    case (state)
      IDLE: begin
        if (efuse_aen_i && !aen_q) begin
          cnt_nxt  = 10'd1;
          addr_nxt = efuse_addr_i;
          if (efuse_pgmen_i && efuse_rden_i) begin
            set_mode  = 1'b1;
            state_nxt = IGNORE;
          end else if (efuse_rden_i) begin
            state_nxt = RD_ACT;
          end else if (efuse_pgmen_i) begin
            state_nxt = PGM_ACT;
          end else begin
            state_nxt = IGNORE;
          end
        end
      end
      RD_ACT, PGM_ACT: begin
        if (state == RD_ACT) mode_bad = !(efuse_rden_i && !efuse_pgmen_i);
        else                 mode_bad = !(efuse_pgmen_i && !efuse_rden_i);
        if (!efuse_aen_i) begin
          state_nxt = IDLE;
          if (state == RD_ACT) begin
            if (cnt >= 10'(TRD_MIN)) begin
              rdata_nxt = fuse[{addr_lat[7:3], 3'b000} +: 8];
            end else begin
              rdata_nxt    = 8'h00;
              set_rd_short = 1'b1;
            end
          end else begin
            if (cnt >= 10'(TPGM_MIN)) pgm_wr = 1'b1;
            else                      set_pgm_short = 1'b1;
          end
        end else if (mode_bad || (efuse_addr_i != addr_lat)) begin
          set_mode  = 1'b1;
          state_nxt = IGNORE;
        end else if (cnt != 10'h3FF) begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      IGNORE: begin
        if (!efuse_aen_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
